// File: rtl/wb_resize_pkg.sv
// Shared definitions for the sequential Wishbone data-width resizer:
// FSM state encoding, latched response codes and a constant clog2 helper.
package wb_resize_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RSP_ACK = 2'd0,
    RSP_ERR = 2'd1,
    RSP_RTY = 2'd2
  } rsp_t;

  // Ceiling log2 for parameter arithmetic; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_resize_lane_sel.sv
// Lane-group picker: among the groups with at least one sel bit set and an
// index strictly below from_idx, returns the highest index. Issuing beats
// from the top group down walks the big-endian byte lanes from the lowest
// address upward. from_idx = RATIO searches all groups.
module wb_resize_lane_sel #(
  parameter int RATIO = 4,
  parameter int SB    = 1,
  parameter int IW    = 2
) (
  input  logic [RATIO*SB-1:0] sel,
  input  logic [IW:0]         from_idx,
  output logic [IW-1:0]       grp_idx,
  output logic                grp_valid
);

  // Ascending scan: the last match (highest eligible group) wins.
  always_comb begin
    grp_idx   = '0;
    grp_valid = 1'b0;
    for (int j = 0; j < RATIO; j++) begin
      if (((IW+1)'(j) < from_idx) && (|sel[j*SB +: SB])) begin
        grp_idx   = IW'(j);
        grp_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_data_resize_seq.sv
// Sequential Wishbone width converter, wide master (MDW) to narrow slave (SDW).
// Every access is split into one classic narrow beat per active lane group,
// lowest address first (big-endian lane order). Read data is assembled over
// the beats and the master sees a single ack/err/rty.
// Optional build macro WB_DATA_RESIZE_TIMEOUT_EN: a per-beat timeout that
// answers err after TIMEOUT silent ACCESS cycles.
//
// Handshake: the master request is taken when wbm_cyc_i & wbm_stb_i are seen
// in IDLE; a slave beat completes on the edge where wbs_cyc_o & wbs_stb_o and
// one of wbs_ack_i/err_i/rty_i are high; the master response is a one-cycle
// pulse of exactly one of wbm_ack_o/err_o/rty_o.
module wb_data_resize_seq
  import wb_resize_pkg::*;
#(
  parameter int AW      = 32,
  parameter int MDW     = 32,
  parameter int SDW     = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [AW-1:0]     wbm_adr_i,
  input  logic [MDW-1:0]    wbm_dat_i,
  input  logic [MDW/8-1:0]  wbm_sel_i,
  input  logic              wbm_we_i,
  input  logic              wbm_cyc_i,
  input  logic              wbm_stb_i,
  input  logic [2:0]        wbm_cti_i,
  input  logic [1:0]        wbm_bte_i,
  output logic [MDW-1:0]    wbm_dat_o,
  output logic              wbm_ack_o,
  output logic              wbm_err_o,
  output logic              wbm_rty_o,
  output logic [AW-1:0]     wbs_adr_o,
  output logic [SDW-1:0]    wbs_dat_o,
  output logic [SDW/8-1:0]  wbs_sel_o,
  output logic              wbs_we_o,
  output logic              wbs_cyc_o,
  output logic              wbs_stb_o,
  output logic [2:0]        wbs_cti_o,
  output logic [1:0]        wbs_bte_o,
  input  logic [SDW-1:0]    wbs_dat_i,
  input  logic              wbs_ack_i,
  input  logic              wbs_err_i,
  input  logic              wbs_rty_i
);

  localparam int RATIO = MDW / SDW;
  localparam int SB    = SDW / 8;
  localparam int SELW  = MDW / 8;
  localparam int LOG   = clog2(SELW);
  localparam int IW    = (RATIO > 1) ? clog2(RATIO) : 1;
  localparam logic [AW-1:0] LOW_MASK = AW'((64'd1 << LOG) - 64'd1);

  state_t          state, state_d;
  rsp_t            rsp, rsp_d;
  logic [AW-1:0]   adr_q;
  logic [MDW-1:0]  dat_q;
  logic [SELW-1:0] sel_q;
  logic            we_q;
  logic [IW-1:0]   cur;
  logic [MDW-1:0]  rd_buf;

  logic [SELW-1:0] sel_src;
  logic [IW:0]     from_idx;
  logic [IW-1:0]   grp_idx;
  logic            grp_valid;
  logic            req;
  logic            beat_adv;

  // Burst type and extension are not needed: every access is served classic.
  logic unused_inputs;
  assign unused_inputs = ^{wbm_cti_i, wbm_bte_i};

  assign req = wbm_cyc_i & wbm_stb_i;

  // A beat completes cleanly (ack without err/rty while the master holds cyc).
  assign beat_adv = (state == ST_ACCESS) && wbm_cyc_i && wbs_ack_i &&
                    !wbs_err_i && !wbs_rty_i;

  // In IDLE search the incoming sel from the top; in ACCESS search below cur.
  assign sel_src  = (state == ST_IDLE) ? wbm_sel_i : sel_q;
  assign from_idx = (state == ST_IDLE) ? (IW+1)'(RATIO) : {1'b0, cur};

  wb_resize_lane_sel #(
    .RATIO (RATIO),
    .SB    (SB),
    .IW    (IW)
  ) u_lane_sel (
    .sel       (sel_src),
    .from_idx  (from_idx),
    .grp_idx   (grp_idx),
    .grp_valid (grp_valid)
  );

`ifdef WB_DATA_RESIZE_TIMEOUT_EN
  localparam int TW = (clog2(TIMEOUT + 1) > 0) ? clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  assign tmo_hit = (state == ST_ACCESS) && (tmo_cnt == TW'(TIMEOUT - 1));

  // Per-beat wait counter, cleared outside ACCESS and whenever a beat completes.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                              tmo_cnt <= '0;
    else if (state != ST_ACCESS || beat_adv)   tmo_cnt <= '0;
    else                                       tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_d;
  end

  // Next-state logic and response code selection.
  always_comb begin
    state_d = state;
    rsp_d   = rsp;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (grp_valid) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_RESP;
            rsp_d   = RSP_ACK;
          end
        end
      end
      ST_ACCESS: begin
        if (!wbm_cyc_i) begin
          state_d = ST_IDLE;
        end else if (wbs_err_i) begin
          state_d = ST_RESP;
          rsp_d   = RSP_ERR;
        end else if (wbs_rty_i) begin
          state_d = ST_RESP;
          rsp_d   = RSP_RTY;
        end else if (wbs_ack_i) begin
          if (!grp_valid) begin
            state_d = ST_RESP;
            rsp_d   = RSP_ACK;
          end
        end
`ifdef WB_DATA_RESIZE_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = ST_RESP;
          rsp_d   = RSP_ERR;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, beat index and read-data assembly.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rsp    <= RSP_ACK;
      adr_q  <= '0;
      dat_q  <= '0;
      sel_q  <= '0;
      we_q   <= 1'b0;
      cur    <= '0;
      rd_buf <= '0;
    end else begin
      rsp <= rsp_d;
      if (state == ST_IDLE && req) begin
        adr_q  <= wbm_adr_i;
        dat_q  <= wbm_dat_i;
        sel_q  <= wbm_sel_i;
        we_q   <= wbm_we_i;
        cur    <= grp_idx;
        rd_buf <= '0;
      end else if (beat_adv) begin
        if (!we_q) rd_buf[cur*SDW +: SDW] <= wbs_dat_i;
        if (grp_valid) cur <= grp_idx;
      end
    end
  end

  // Outputs decoded from state; everything is zero outside its active phase.
  always_comb begin
    wbs_cyc_o = (state == ST_ACCESS);
    wbs_stb_o = (state == ST_ACCESS);
    wbs_we_o  = (state == ST_ACCESS) && we_q;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_cti_o = 3'b000;
    wbs_bte_o = 2'b00;
    if (state == ST_ACCESS) begin
      wbs_adr_o = (adr_q & ~LOW_MASK) | AW'((RATIO - 1 - int'(cur)) * SB);
      wbs_dat_o = dat_q[cur*SDW +: SDW];
      wbs_sel_o = sel_q[cur*SB +: SB];
    end
    wbm_ack_o = (state == ST_RESP) && (rsp == RSP_ACK);
    wbm_err_o = (state == ST_RESP) && (rsp == RSP_ERR);
    wbm_rty_o = (state == ST_RESP) && (rsp == RSP_RTY);
    wbm_dat_o = (state == ST_RESP) ? rd_buf : '0;
  end

endmodule

// File: tb/tb_wb_data_resize_seq.sv
// Directed bench for wb_data_resize_seq (32 -> 8, TIMEOUT = 8) with a
// scripted narrow slave and an expected-beat queue.
module tb_wb_data_resize_seq;

  localparam int AW  = 32;
  localparam int MDW = 32;
  localparam int SDW = 8;
  localparam int BW  = 1 + AW + SDW/8 + SDW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [AW-1:0]     m_adr = '0;
  logic [MDW-1:0]    m_dat = '0;
  logic [MDW/8-1:0]  m_sel = '0;
  logic              m_we  = 1'b0;
  logic              m_cyc = 1'b0;
  logic              m_stb = 1'b0;
  logic [2:0]        m_cti = '0;
  logic [1:0]        m_bte = '0;
  logic [MDW-1:0]    wbm_dat_o;
  logic              wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [SDW-1:0]    wbs_dat_o;
  logic [SDW/8-1:0]  wbs_sel_o;
  logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic [SDW-1:0]    wbs_dat_i;
  logic              wbs_ack_i, wbs_err_i, wbs_rty_i;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];

  // Slave model configuration (driven by the stimulus block).
  int   slv_wait   = 0;
  int   slv_err_at = -1;
  int   slv_rty_at = -1;
  bit   slv_silent = 1'b0;
  int   wcnt       = 0;
  int   beat_no    = 0;
  logic slv_active;
  logic [31:0] slv_word = 32'h11223344;

  wb_data_resize_seq #(.AW(AW), .MDW(MDW), .SDW(SDW), .TIMEOUT(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbm_adr_i (m_adr),
    .wbm_dat_i (m_dat),
    .wbm_sel_i (m_sel),
    .wbm_we_i  (m_we),
    .wbm_cyc_i (m_cyc),
    .wbm_stb_i (m_stb),
    .wbm_cti_i (m_cti),
    .wbm_bte_i (m_bte),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_o (wbm_ack_o),
    .wbm_err_o (wbm_err_o),
    .wbm_rty_o (wbm_rty_o),
    .wbs_adr_o (wbs_adr_o),
    .wbs_dat_o (wbs_dat_o),
    .wbs_sel_o (wbs_sel_o),
    .wbs_we_o  (wbs_we_o),
    .wbs_cyc_o (wbs_cyc_o),
    .wbs_stb_o (wbs_stb_o),
    .wbs_cti_o (wbs_cti_o),
    .wbs_bte_o (wbs_bte_o),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_i (wbs_ack_i),
    .wbs_err_i (wbs_err_i),
    .wbs_rty_i (wbs_rty_i)
  );

  // Clock.
  always #5 clk = ~clk;

  // Narrow slave: answers after slv_wait wait states; byte at offset k of
  // slv_word (big-endian) is returned for address low bits k.
  assign slv_active = wbs_cyc_o && wbs_stb_o && !slv_silent && (wcnt == slv_wait);
  assign wbs_rty_i  = slv_active && (beat_no == slv_rty_at);
  assign wbs_err_i  = slv_active && (beat_no == slv_err_at);
  assign wbs_ack_i  = slv_active && (beat_no != slv_rty_at);
  assign wbs_dat_i  = slv_active ? slv_word[(3 - int'(wbs_adr_o[1:0]))*8 +: 8] : 8'h00;

  always @(posedge clk) begin
    if (wbs_cyc_o && wbs_stb_o) begin
      if (slv_active) begin
        wcnt    <= 0;
        beat_no <= beat_no + 1;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push_beat(input logic we, input logic [AW-1:0] adr,
                           input logic [SDW/8-1:0] sel, input logic [SDW-1:0] dat);
    exp_q.push_back({we, adr, sel, dat});
  endtask

  // Beat monitor: compares each completed slave beat against the queue head.
  always @(negedge clk) begin
    if (wbs_cyc_o && wbs_stb_o && (wbs_ack_i || wbs_err_i || wbs_rty_i)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {22'd0, wbs_we_o, wbs_adr_o, wbs_sel_o, wbs_dat_o}, 64'd0);
      end else begin
        check("beat", {22'd0, wbs_we_o, wbs_adr_o, wbs_sel_o, wbs_dat_o},
              {22'd0, exp_q.pop_front()});
      end
    end
  end

  // Issue one master access and check response kind, cycle, data and pulse width.
  task automatic do_access(input logic [AW-1:0] adr, input logic [MDW-1:0] dat,
                           input logic [3:0] sel, input logic we, input logic [2:0] cti,
                           input logic [2:0] exp_flags, input int exp_cyc,
                           input bit chk_dat, input logic [MDW-1:0] exp_dat);
    int n;
    bit got;
    @(negedge clk);
    m_adr = adr; m_dat = dat; m_sel = sel; m_we = we; m_cti = cti;
    m_cyc = 1'b1; m_stb = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) got = 1'b1;
    end
    check("resp_seen", 64'(got), 64'd1);
    if (got) begin
      check("resp_kind", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'(exp_flags));
      check("resp_cycle", 64'(n), 64'(exp_cyc));
      if (chk_dat) check("rdata", 64'(wbm_dat_o), 64'(exp_dat));
    end
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_cti = '0;
    @(negedge clk);
    check("resp_one_cycle", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'd0);
    check("beats_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  int seen;

  initial begin
    // Reset and idle outputs.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_master", {29'd0, wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o}, 64'd0);
    check("reset_slave", {10'd0, wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o,
                          wbs_stb_o, wbs_cti_o, wbs_bte_o}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full-word read, zero-wait slave.
    push_beat(1'b0, 32'h90000004, 1'b1, 8'h00);
    push_beat(1'b0, 32'h90000005, 1'b1, 8'h00);
    push_beat(1'b0, 32'h90000006, 1'b1, 8'h00);
    push_beat(1'b0, 32'h90000007, 1'b1, 8'h00);
    do_access(32'h90000004, 32'h0, 4'hF, 1'b0, 3'b000, 3'b100, 5, 1'b1, 32'h11223344);

    // Sparse write with a burst cti, served as classic beats.
    push_beat(1'b1, 32'h90000005, 1'b1, 8'hBB);
    push_beat(1'b1, 32'h90000007, 1'b1, 8'hDD);
    do_access(32'h90000004, 32'hAABBCCDD, 4'b0101, 1'b1, 3'b010, 3'b100, 3, 1'b1, 32'h0);

    // No active lanes: immediate ack, no slave cycle.
    do_access(32'h90000008, 32'h0, 4'h0, 1'b0, 3'b000, 3'b100, 1, 1'b1, 32'h0);

    // Single top-lane read with two wait states.
    slv_wait = 2;
    push_beat(1'b0, 32'h90000004, 1'b1, 8'h00);
    do_access(32'h90000004, 32'h0, 4'b1000, 1'b0, 3'b000, 3'b100, 4, 1'b1, 32'h11000000);
    slv_wait = 0;

    // Error on the second beat (ack and err together): err wins, rest abandoned.
    slv_err_at = beat_no + 1;
    push_beat(1'b0, 32'h90000004, 1'b1, 8'h00);
    push_beat(1'b0, 32'h90000005, 1'b1, 8'h00);
    do_access(32'h90000004, 32'h0, 4'hF, 1'b0, 3'b000, 3'b010, 3, 1'b0, 32'h0);
    slv_err_at = -1;

    // Retry on the first beat.
    slv_rty_at = beat_no;
    push_beat(1'b0, 32'h90000006, 1'b1, 8'h00);
    do_access(32'h90000004, 32'h0, 4'b0011, 1'b0, 3'b000, 3'b001, 2, 1'b0, 32'h0);
    slv_rty_at = -1;

    // Master abort during a waited beat.
    slv_wait = 2;
    @(negedge clk);
    m_adr = 32'h90000004; m_sel = 4'hF; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_cyc_before", 64'(wbs_cyc_o), 64'd1);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    check("abort_cyc_after", 64'({wbs_cyc_o, wbs_stb_o}), 64'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) seen++;
    end
    check("abort_no_resp", 64'(seen), 64'd0);
    slv_wait = 0;

    // Clean request after the abort; unaligned address low bits are ignored.
    push_beat(1'b0, 32'h90000005, 1'b1, 8'h00);
    push_beat(1'b0, 32'h90000006, 1'b1, 8'h00);
    do_access(32'h90000007, 32'h0, 4'b0110, 1'b0, 3'b000, 3'b100, 3, 1'b1, 32'h00223300);

    // Reset in the middle of an access.
    slv_wait = 5;
    @(negedge clk);
    m_adr = 32'h90000004; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    check("rst_mid_slave", 64'({wbs_cyc_o, wbs_stb_o}), 64'd0);
    check("rst_mid_master", 64'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 64'd0);
    rst = 1'b0;
    slv_wait = 0;
    @(negedge clk);

    // Silent slave.
    slv_silent = 1'b1;
`ifdef WB_DATA_RESIZE_TIMEOUT_EN
    do_access(32'h90000004, 32'h0, 4'b1000, 1'b0, 3'b000, 3'b010, 9, 1'b0, 32'h0);
`else
    @(negedge clk);
    m_adr = 32'h90000004; m_sel = 4'b1000; m_cyc = 1'b1; m_stb = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) seen++;
    end
    check("silent_no_resp", 64'(seen), 64'd0);
    check("silent_waiting", 64'({wbs_cyc_o, wbs_stb_o}), 64'd3);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    check("silent_abort", 64'(wbs_cyc_o), 64'd0);
`endif
    slv_silent = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
